terminate_issue_queue: RTL and testbench

- In-order issue queue that feeds the terminate (branch-resolution) pipeline.
- Holds up to DEPTH decoded terminate instructions. Captures the 16-bit base register value and the 8-bit flag vector from two wakeup buses, then issues the head entry once both operands are present.
- Sits between rename/dispatch and the terminate pipeline. A global flush empties the queue.

---
 rtl/terminate_issue_queue_pkg.sv | 25 ++
 rtl/terminate_issue_queue_entry.sv | 84 ++++++++
 rtl/terminate_issue_queue.sv | 121 ++++++++++++
 tb/tb_terminate_issue_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/terminate_issue_queue_pkg.sv
// Shared types and constants for the terminate issue queue.
package terminate_issue_queue_pkg;

    // Width of a physical-register or flag-group tag.
    localparam int TIQ_TAG_W = 6;

    // Opcode bit 0 selects the terminate flavour.
    localparam logic OP_SEL_IMM_ADD     = 1'b1;
    localparam logic OP_SEL_COND_OFFSET = 1'b0;

    // Payload carried by every queue slot. Widths are 4/8/4/16/8.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [7:0]  offset;
        logic [3:0]  immediate;
        logic [15:0] base_val;
        logic [7:0]  flag_val;
    } tiq_fields_t;

    // True when the opcode requests the immediate-add flavour.
    function automatic logic is_imm_add(input logic [3:0] op);
        return op[0] == OP_SEL_IMM_ADD;
    endfunction

endpackage

// File: rtl/terminate_issue_queue_entry.sv
// One issue-queue slot: payload storage, operand wakeup and ready logic.
module tiq_entry
    import terminate_issue_queue_pkg::*;
#(
    parameter int TAG_W = TIQ_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_write,
    input  logic              i_clear,
    input  tiq_fields_t       i_fields,
    input  logic              i_base_ready,
    input  logic [TAG_W-1:0]  i_base_tag,
    input  logic              i_flag_ready,
    input  logic [TAG_W-1:0]  i_flag_tag,
    input  logic              i_reg_wake_valid,
    input  logic [TAG_W-1:0]  i_reg_wake_tag,
    input  logic [15:0]       i_reg_wake_data,
    input  logic              i_flag_wake_valid,
    input  logic [TAG_W-1:0]  i_flag_wake_tag,
    input  logic [7:0]        i_flag_wake_data,
    output logic              o_valid,
    output logic              o_ready,
    output tiq_fields_t       o_fields
);

    logic              r_valid;
    logic              r_base_rdy;
    logic              r_flag_rdy;
    logic [TAG_W-1:0]  r_base_tag;
    logic [TAG_W-1:0]  r_flag_tag;
    tiq_fields_t       r_fields;

    // A broadcast in the enqueue cycle is caught here, otherwise it would be missed.
    logic w_enq_base_hit;
    logic w_enq_flag_hit;
    logic w_res_base_hit;
    logic w_res_flag_hit;

    assign w_enq_base_hit = ~i_base_ready & i_reg_wake_valid  & (i_reg_wake_tag  == i_base_tag);
    assign w_enq_flag_hit = ~i_flag_ready & i_flag_wake_valid & (i_flag_wake_tag == i_flag_tag);
    // Only waiting operands listen; ready ones keep their captured value.
    assign w_res_base_hit = r_valid & ~r_base_rdy & i_reg_wake_valid  & (i_reg_wake_tag  == r_base_tag);
    assign w_res_flag_hit = r_valid & ~r_flag_rdy & i_flag_wake_valid & (i_flag_wake_tag == r_flag_tag);

    // Slot state: flush beats write, write beats pop/wakeup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_base_rdy <= 1'b0;
            r_flag_rdy <= 1'b0;
            r_base_tag <= '0;
            r_flag_tag <= '0;
            r_fields   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_valid    <= 1'b1;
            r_fields   <= i_fields;
            r_base_tag <= i_base_tag;
            r_flag_tag <= i_flag_tag;
            r_base_rdy <= i_base_ready | w_enq_base_hit;
            r_flag_rdy <= i_flag_ready | w_enq_flag_hit;
            if (w_enq_base_hit) r_fields.base_val <= i_reg_wake_data;
            if (w_enq_flag_hit) r_fields.flag_val <= i_flag_wake_data;
        end else begin
            if (i_clear) r_valid <= 1'b0;
            if (w_res_base_hit) begin
                r_base_rdy        <= 1'b1;
                r_fields.base_val <= i_reg_wake_data;
            end
            if (w_res_flag_hit) begin
                r_flag_rdy        <= 1'b1;
                r_fields.flag_val <= i_flag_wake_data;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_ready  = r_base_rdy & r_flag_rdy;
    assign o_fields = r_fields;

endmodule

// File: rtl/terminate_issue_queue.sv
// In-order issue queue feeding the terminate (branch-resolution) pipeline.
module terminate_issue_queue
    import terminate_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TIQ_TAG_W,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [3:0]        enq_opcode,
    input  logic [7:0]        enq_offset,
    input  logic [3:0]        enq_immediate,
    input  logic              enq_base_ready,
    input  logic [TAG_W-1:0]  enq_base_tag,
    input  logic [15:0]       enq_base_val,
    input  logic              enq_flag_ready,
    input  logic [TAG_W-1:0]  enq_flag_tag,
    input  logic [7:0]        enq_flag_val,
    input  logic              reg_wake_valid,
    input  logic [TAG_W-1:0]  reg_wake_tag,
    input  logic [15:0]       reg_wake_data,
    input  logic              flag_wake_valid,
    input  logic [TAG_W-1:0]  flag_wake_tag,
    input  logic [7:0]        flag_wake_data,
    input  logic              flush,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [15:0]       reg_base_val,
    output logic [7:0]        flag_vals,
    output logic [7:0]        offset,
    output logic [3:0]        immediate,
    output logic              empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_enq;
    logic             w_pop;
    tiq_fields_t      w_enq_fields;
    tiq_fields_t      w_head_fields;
    logic             w_valid  [DEPTH];
    logic             w_ready  [DEPTH];
    tiq_fields_t      w_fields [DEPTH];

    assign enq_ready    = (r_count != FULL_COUNT);
    assign empty        = (r_count == '0);
    assign w_enq        = enq_valid & enq_ready & ~flush;
    assign instr_valid  = w_valid[r_head] & w_ready[r_head] & ~flush;
    assign w_pop        = instr_valid & instr_ready;

    assign w_enq_fields = '{opcode:    enq_opcode,
                            offset:    enq_offset,
                            immediate: enq_immediate,
                            base_val:  enq_base_val,
                            flag_val:  enq_flag_val};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            tiq_entry #(.TAG_W(TAG_W)) u_entry (
                .clk               (clk),
                .rst               (rst),
                .i_flush           (flush),
                .i_write           (w_enq && (r_tail == PTR_W'(gi))),
                .i_clear           (w_pop && (r_head == PTR_W'(gi))),
                .i_fields          (w_enq_fields),
                .i_base_ready      (enq_base_ready),
                .i_base_tag        (enq_base_tag),
                .i_flag_ready      (enq_flag_ready),
                .i_flag_tag        (enq_flag_tag),
                .i_reg_wake_valid  (reg_wake_valid),
                .i_reg_wake_tag    (reg_wake_tag),
                .i_reg_wake_data   (reg_wake_data),
                .i_flag_wake_valid (flag_wake_valid),
                .i_flag_wake_tag   (flag_wake_tag),
                .i_flag_wake_data  (flag_wake_data),
                .o_valid           (w_valid[gi]),
                .o_ready           (w_ready[gi]),
                .o_fields          (w_fields[gi])
            );
        end
    endgenerate

    // Data outputs always expose the head slot, issued or not.
    assign w_head_fields = w_fields[r_head];
    assign opcode        = w_head_fields.opcode;
    assign reg_base_val  = w_head_fields.base_val;
    assign flag_vals     = w_head_fields.flag_val;
    assign offset        = w_head_fields.offset;
    assign immediate     = w_head_fields.immediate;

    // Pointer and occupancy bookkeeping; flush rewinds everything to slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_terminate_issue_queue.sv
// Directed self-checking bench for terminate_issue_queue.
module tb_terminate_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [3:0]  enq_opcode;
    logic [7:0]  enq_offset;
    logic [3:0]  enq_immediate;
    logic        enq_base_ready;
    logic [5:0]  enq_base_tag;
    logic [15:0] enq_base_val;
    logic        enq_flag_ready;
    logic [5:0]  enq_flag_tag;
    logic [7:0]  enq_flag_val;
    logic        reg_wake_valid;
    logic [5:0]  reg_wake_tag;
    logic [15:0] reg_wake_data;
    logic        flag_wake_valid;
    logic [5:0]  flag_wake_tag;
    logic [7:0]  flag_wake_data;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  opcode;
    logic [15:0] reg_base_val;
    logic [7:0]  flag_vals;
    logic [7:0]  offset;
    logic [3:0]  immediate;
    logic        empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    terminate_issue_queue #(.DEPTH(4), .TAG_W(6), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_opcode(enq_opcode), .enq_offset(enq_offset), .enq_immediate(enq_immediate),
        .enq_base_ready(enq_base_ready), .enq_base_tag(enq_base_tag), .enq_base_val(enq_base_val),
        .enq_flag_ready(enq_flag_ready), .enq_flag_tag(enq_flag_tag), .enq_flag_val(enq_flag_val),
        .reg_wake_valid(reg_wake_valid), .reg_wake_tag(reg_wake_tag), .reg_wake_data(reg_wake_data),
        .flag_wake_valid(flag_wake_valid), .flag_wake_tag(flag_wake_tag), .flag_wake_data(flag_wake_data),
        .flush(flush), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .reg_base_val(reg_base_val), .flag_vals(flag_vals),
        .offset(offset), .immediate(immediate), .empty(empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present one dispatch for a single cycle.
    task automatic enq(input logic [3:0] op, input logic [7:0] off, input logic [3:0] imm,
                       input logic brdy, input logic [5:0] btag, input logic [15:0] bval,
                       input logic frdy, input logic [5:0] ftag, input logic [7:0] fval);
        enq_valid = 1'b1; enq_opcode = op; enq_offset = off; enq_immediate = imm;
        enq_base_ready = brdy; enq_base_tag = btag; enq_base_val = bval;
        enq_flag_ready = frdy; enq_flag_tag = ftag; enq_flag_val = fval;
        tick();
        enq_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enq_valid = 0; enq_opcode = 0; enq_offset = 0; enq_immediate = 0;
        enq_base_ready = 0; enq_base_tag = 0; enq_base_val = 0;
        enq_flag_ready = 0; enq_flag_tag = 0; enq_flag_val = 0;
        reg_wake_valid = 0; reg_wake_tag = 0; reg_wake_data = 0;
        flag_wake_valid = 0; flag_wake_tag = 0; flag_wake_data = 0;
        flush = 0; instr_ready = 0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_instr_valid", instr_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_enq_ready", enq_ready, 1);

        // Fully ready entry issues the next cycle and pops.
        enq(4'h1, 8'h10, 4'h3, 1, 6'd0, 16'h1234, 1, 6'd0, 8'hA5);
        settle();
        check("t1_valid", instr_valid, 1);
        check("t1_opcode", opcode, 4'h1);
        check("t1_base", reg_base_val, 16'h1234);
        check("t1_flags", flag_vals, 8'hA5);
        check("t1_offset", offset, 8'h10);
        check("t1_imm", immediate, 4'h3);
        check("t1_empty", empty, 0);
        instr_ready = 1; tick(); instr_ready = 0; settle();
        check("t1_pop_empty", empty, 1);
        check("t1_pop_valid", instr_valid, 0);

        // Resident base wakeup: one-cycle wake-to-issue latency.
        enq(4'h2, 8'h20, 4'h1, 0, 6'd5, 16'h0000, 1, 6'd0, 8'h11);
        settle();
        check("t2_wait", instr_valid, 0);
        reg_wake_valid = 1; reg_wake_tag = 6'd6; reg_wake_data = 16'hDEAD;
        tick(); settle();
        check("t2_wrong_tag", instr_valid, 0);
        reg_wake_tag = 6'd5; reg_wake_data = 16'h8000; settle();
        check("t2_wake_cycle", instr_valid, 0);
        tick(); reg_wake_valid = 0; settle();
        check("t2_issue", instr_valid, 1);
        check("t2_base", reg_base_val, 16'h8000);
        reg_wake_valid = 1; reg_wake_tag = 6'd5; reg_wake_data = 16'h1111;
        tick(); reg_wake_valid = 0; settle();
        check("t2_ignore_late", reg_base_val, 16'h8000);
        instr_ready = 1; tick(); instr_ready = 0; settle();
        check("t2_empty", empty, 1);

        // Enqueue-time flag wakeup.
        flag_wake_valid = 1; flag_wake_tag = 6'd9; flag_wake_data = 8'h3C;
        enq(4'h3, 8'h30, 4'h2, 1, 6'd0, 16'h0042, 0, 6'd9, 8'h00);
        flag_wake_valid = 0; settle();
        check("t3_issue", instr_valid, 1);
        check("t3_flags", flag_vals, 8'h3C);
        check("t3_base", reg_base_val, 16'h0042);
        instr_ready = 1; tick(); instr_ready = 0; settle();

        // Fill to full (pointers wrap), then pop while dispatch is offered.
        for (int i = 0; i < 4; i++)
            enq(4'(4 + i), 8'(i), 4'(i), 1, 6'd0, 16'(16'h0100 + i), 1, 6'd0, 8'(i));
        settle();
        check("t4_full_ready", enq_ready, 0);
        check("t4_head_op", opcode, 4'h4);
        enq_valid = 1; enq_opcode = 4'hF; enq_base_ready = 1; enq_flag_ready = 1;
        instr_ready = 1; settle();
        check("t4_full_ready2", enq_ready, 0);
        tick(); enq_valid = 0; instr_ready = 0; settle();
        check("t4_ready_after", enq_ready, 1);
        instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t4_drain%0d_valid", i), instr_valid, 1);
            check($sformatf("t4_drain%0d_op", i), opcode, 4'(5 + i));
            check($sformatf("t4_drain%0d_base", i), reg_base_val, 16'(16'h0101 + i));
            tick();
        end
        instr_ready = 0; settle();
        check("t4_empty", empty, 1);

        // In-order blocking: head waits on tag 7, younger is ready.
        instr_ready = 1;
        enq(4'h2, 8'h00, 4'h0, 0, 6'd7, 16'h0000, 1, 6'd0, 8'h01);
        enq(4'h3, 8'h00, 4'h0, 1, 6'd0, 16'h3333, 1, 6'd0, 8'h02);
        settle();
        check("t5_blocked0", instr_valid, 0);
        tick();
        check("t5_blocked1", instr_valid, 0);
        reg_wake_valid = 1; reg_wake_tag = 6'd7; reg_wake_data = 16'h7777;
        tick(); reg_wake_valid = 0; settle();
        check("t5_first_valid", instr_valid, 1);
        check("t5_first_op", opcode, 4'h2);
        check("t5_first_base", reg_base_val, 16'h7777);
        tick();
        check("t5_second_valid", instr_valid, 1);
        check("t5_second_op", opcode, 4'h3);
        check("t5_second_base", reg_base_val, 16'h3333);
        tick();
        check("t5_empty", empty, 1);
        instr_ready = 0;

        // Flush with a same-cycle enqueue drops everything.
        for (int i = 0; i < 3; i++)
            enq(4'(8 + i), 8'h00, 4'h0, 1, 6'd0, 16'h0000, 1, 6'd0, 8'h00);
        settle();
        check("t6_pre_valid", instr_valid, 1);
        flush = 1; enq_valid = 1; enq_opcode = 4'hD; settle();
        check("t6_flush_forced", instr_valid, 0);
        tick(); flush = 0; enq_valid = 0; settle();
        check("t6_empty", empty, 1);
        check("t6_valid", instr_valid, 0);
        check("t6_enq_ready", enq_ready, 1);
        enq(4'hC, 8'h55, 4'h5, 1, 6'd0, 16'hCAFE, 1, 6'd0, 8'h66);
        settle();
        check("t6_new_op", opcode, 4'hC);
        check("t6_new_base", reg_base_val, 16'hCAFE);
        instr_ready = 1; tick(); instr_ready = 0; settle();
        check("t6_new_empty", empty, 1);

        // Asynchronous reset mid-operation.
        enq(4'h6, 8'h00, 4'h0, 1, 6'd0, 16'h0000, 1, 6'd0, 8'h00);
        settle();
        check("t7_pre_empty", empty, 0);
        rst = 1; #1;
        check("t7_async_empty", empty, 1);
        check("t7_async_valid", instr_valid, 0);
        tick(); rst = 0; settle();
        check("t7_after_ready", enq_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
